clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_halfcyc.sv | 16 +
 rtl/clk_div_prog.sv | 122 ++++++++++++
 tb/tb_clk_div_prog.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;
   localparam int unsigned CLK_DIV_WIDTH   = 8;
   localparam int unsigned CLK_DIV_DEFAULT = 12;
   localparam int unsigned MIN_DIV         = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;
endpackage

// File: rtl/clk_div_halfcyc.sv
// Negedge re-registration of pos_q; used to trim odd-divisor high time by half a clock.
module clk_div_halfcyc (
   input  logic clk,
   input  logic reset,
   input  logic pos_q,
   output logic neg_q
);
   logic r_neg_q;

   always_ff @(negedge clk) begin
      if (reset) r_neg_q <= 1'b0;
      else       r_neg_q <= pos_q;
   end

   assign neg_q = r_neg_q;
endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: 50% duty for even and odd N, deferred divisor
// updates at period boundaries, clean stop/start on en.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH       = CLK_DIV_WIDTH,
   parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   output logic             out,
   output logic             tick,
   output logic             ack,
   output logic             err
);
   run_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_div, w_div_nxt;
   logic [WIDTH-1:0] r_pend, w_pend_nxt;
   logic             r_pend_vld, w_pend_vld_nxt;
   logic             r_pos_q, w_pos_nxt;
   logic             r_ack, w_ack_nxt;
   logic             r_err, w_err_nxt;
   logic             w_neg_q;
   logic             w_legal;
   logic             w_wrap;
   logic [WIDTH:0]   w_cnt_inc;
   logic [WIDTH:0]   w_half;

   assign w_legal   = (div_in >= WIDTH'(MIN_DIV));
   assign w_wrap    = (r_state == ST_RUN) && (r_cnt == (r_div - 1'b1));
   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   assign w_half    = ({1'b0, r_div} + 1'b1) >> 1;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_div_nxt      = r_div;
      w_pend_nxt     = r_pend;
      w_pend_vld_nxt = r_pend_vld;
      w_pos_nxt      = r_pos_q;
      w_ack_nxt      = 1'b0;
      w_err_nxt      = load && !w_legal;

      unique case (r_state)
         ST_IDLE: begin
            if (load && w_legal) begin
               w_div_nxt = div_in;
               w_ack_nxt = 1'b1;
            end
            if (en) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_pos_nxt   = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_wrap) begin
               w_cnt_nxt = '0;
               if (r_pend_vld) begin
                  w_div_nxt      = r_pend;
                  w_pend_vld_nxt = 1'b0;
                  w_ack_nxt      = 1'b1;
               end
               if (en) begin
                  w_pos_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_pos_nxt   = 1'b0;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc[WIDTH-1:0];
               w_pos_nxt = (w_cnt_inc < w_half);
            end
            // Evaluated after the wrap: a load landing on the wrap edge waits for the next one.
            if (load && w_legal) begin
               w_pend_nxt     = div_in;
               w_pend_vld_nxt = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_div      <= WIDTH'(DEFAULT_DIV);
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_pos_q    <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_div      <= w_div_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_pos_q    <= w_pos_nxt;
         r_ack      <= w_ack_nxt;
         r_err      <= w_err_nxt;
      end
   end

   clk_div_halfcyc u_halfcyc (
      .clk   (clk),
      .reset (reset),
      .pos_q (r_pos_q),
      .neg_q (w_neg_q)
   );

   // Divisor changes only at a wrap, where pos_q and neg_q are both low, so the mode switch is hazard-free.
   assign out  = r_div[0] ? (r_pos_q & w_neg_q) : r_pos_q;
   assign tick = (r_state == ST_RUN) && (r_cnt == '0);
   assign ack  = r_ack;
   assign err  = r_err;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle vector table plus multi-cycle sequences.
module tb_clk_div_prog;
   logic       clk;
   logic       reset;
   logic       en;
   logic       load;
   logic [7:0] div_in;
   logic       out;
   logic       tick;
   logic       ack;
   logic       err;

   int tests;
   int fails;

   typedef struct {
      logic       en;
      logic       load;
      logic [7:0] div;
      logic       e_out1;
      logic       e_out2;
      logic       e_tick;
      logic       e_ack;
      logic       e_err;
   } vec_t;

   vec_t vt[19];

   clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(12)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .load   (load),
      .div_in (div_in),
      .out    (out),
      .tick   (tick),
      .ack    (ack),
      .err    (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic posedge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic negedge_sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input logic run_en);
      reset  = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      div_in = '0;
      posedge_sample();
      reset = 1'b0;
      en    = run_en;
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      reset  = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      div_in = '0;

      //          en  ld  div    o1  o2  tk  ak  er
      vt[0]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[1]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[12] = '{1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[13] = '{1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[14] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[15] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[16] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[17] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[18] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      posedge_sample();
      posedge_sample();
      chk("rst_out",  out,  1'b0);
      chk("rst_tick", tick, 1'b0);
      chk("rst_ack",  ack,  1'b0);
      chk("rst_err",  err,  1'b0);
      reset = 1'b0;

      // Vector table: illegal loads, idle load, odd N=3, en stop, even N=4 -> 2 pending
      for (int i = 0; i < 19; i++) begin
         en     = vt[i].en;
         load   = vt[i].load;
         div_in = vt[i].div;
         posedge_sample();
         chk($sformatf("vec%0d_tick", i), tick, vt[i].e_tick);
         chk($sformatf("vec%0d_ack", i),  ack,  vt[i].e_ack);
         chk($sformatf("vec%0d_err", i),  err,  vt[i].e_err);
         chk($sformatf("vec%0d_out1", i), out,  vt[i].e_out1);
         negedge_sample();
         chk($sformatf("vec%0d_out2", i), out,  vt[i].e_out2);
      end
      load = 1'b0;

      // Default N=12 after reset: 6 high / 6 low, tick every 12
      do_reset(1'b1);
      for (int k = 0; k < 24; k++) begin
         posedge_sample();
         chk("A_tick", tick, (k % 12) == 0);
         chk("A_out",  out,  (k % 12) < 6);
      end

      // Load 9 mid-period: 12-period completes, ack at wrap, then 4.5/4.5
      for (int j = 0; j < 3; j++) begin
         posedge_sample();
         chk("B_pre_out", out, 1'b1);
      end
      load   = 1'b1;
      div_in = 8'd9;
      for (int j = 3; j < 12; j++) begin
         posedge_sample();
         load = 1'b0;
         chk("B_ack_hold", ack, 1'b0);
         chk("B_out12",    out, j < 6);
      end
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < 9; j++) begin
            posedge_sample();
            chk("B_tick",    tick, j == 0);
            chk("B_ack",     ack,  (p == 0) && (j == 0));
            chk("B_out_hi1", out,  (j >= 1) && (j <= 4));
            negedge_sample();
            chk("B_out_hi2", out,  j <= 4);
         end
      end

      // Load 80 then 2 before the wrap: only N=2 applied, single ack
      posedge_sample();
      posedge_sample();
      load   = 1'b1;
      div_in = 8'd80;
      posedge_sample();
      load = 1'b0;
      posedge_sample();
      load   = 1'b1;
      div_in = 8'd2;
      posedge_sample();
      load = 1'b0;
      for (int k = 1; k < 12; k++) begin
         posedge_sample();
         chk("C_ack",  ack,  k == 5);
         chk("C_tick", tick, (k >= 5) && (k % 2 == 1));
         chk("C_out",  out,  (k >= 5) && (k % 2 == 1));
      end

      // Illegal loads 1 and 0 while running N=2
      load   = 1'b1;
      div_in = 8'd1;
      posedge_sample();
      chk("D_err1", err, 1'b1);
      chk("D_ack1", ack, 1'b0);
      chk("D_out1", out, 1'b0);
      div_in = 8'd0;
      posedge_sample();
      load = 1'b0;
      chk("D_err0",  err,  1'b1);
      chk("D_ack0",  ack,  1'b0);
      chk("D_tick0", tick, 1'b1);
      posedge_sample();
      chk("D_err_clr", err,  1'b0);
      chk("D_tick1",   tick, 1'b0);
      chk("D_out_lo",  out,  1'b0);

      // Load on the wrap edge: applied at the following wrap
      load   = 1'b1;
      div_in = 8'd5;
      posedge_sample();
      load = 1'b0;
      chk("W_ack_not_yet", ack,  1'b0);
      chk("W_tick",        tick, 1'b1);
      chk("W_out_n2",      out,  1'b1);
      posedge_sample();
      chk("W_ack_hold", ack, 1'b0);
      posedge_sample();
      chk("W_ack",      ack,  1'b1);
      chk("W_tick5",    tick, 1'b1);
      chk("W_out_h1",   out,  1'b0);
      negedge_sample();
      chk("W_out_h2",   out,  1'b1);
      for (int j = 1; j < 6; j++) begin
         posedge_sample();
         chk("W_tick_n5", tick, j == 5);
         chk("W_ack_n5",  ack,  1'b0);
         chk("W_out_n5",  out,  (j == 1) || (j == 2));
      end

      // en dropped at cnt=3: period completes, stays low, restart on re-raise
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         posedge_sample();
         chk("E_tick_start", tick, k == 0);
         chk("E_out_start",  out,  1'b1);
      end
      en = 1'b0;
      for (int k = 4; k < 17; k++) begin
         posedge_sample();
         chk("E_out_finish", out,  k < 6);
         chk("E_tick_off",   tick, 1'b0);
      end
      en = 1'b1;
      posedge_sample();
      chk("E_restart_tick", tick, 1'b1);
      chk("E_restart_out",  out,  1'b1);

      // Reset at cnt=5 with a load pending: abort, default N, no ack
      do_reset(1'b1);
      for (int k = 0; k < 6; k++) begin
         posedge_sample();
         chk("F_tick", tick, k == 0);
         chk("F_out",  out,  1'b1);
         if (k == 2) begin
            load   = 1'b1;
            div_in = 8'd9;
         end else begin
            load = 1'b0;
         end
      end
      reset = 1'b1;
      posedge_sample();
      chk("F_rst_out",  out,  1'b0);
      chk("F_rst_tick", tick, 1'b0);
      chk("F_rst_ack",  ack,  1'b0);
      negedge_sample();
      chk("F_rst_out2", out,  1'b0);
      reset = 1'b0;
      en    = 1'b1;
      for (int k = 0; k < 14; k++) begin
         posedge_sample();
         chk("F_post_tick", tick, (k % 12) == 0);
         chk("F_post_out",  out,  (k % 12) < 6);
         chk("F_post_ack",  ack,  1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
